galaga_input_conditioner: RTL

- Upstream front end of the GALAGA game core. Takes six raw, asynchronous push-button lines: left, right and fire for each of two ships.
- Per button: synchronises, debounces and converts each press into a single-cycle pulse.
- Drives the core's LEFT, RIGHT, LEFT2, RIGHT2, DP1 and DP2 inputs.
- Suppresses contradictory steering and freezes all commands while the core reports DONE.

---
 rtl/galaga_input_pkg.sv | 18 +
 rtl/galaga_input_conditioner_debounce.sv | 52 +++++
 rtl/galaga_input_conditioner.sv | 124 ++++++++++++
 3 files changed

// File: rtl/galaga_input_pkg.sv
// Shared constants for the GALAGA input conditioner: button indices and parameter defaults.
package galaga_input_pkg;

    localparam int NUM_BTN = 6;

    localparam int IDX_L1 = 0;
    localparam int IDX_R1 = 1;
    localparam int IDX_F1 = 2;
    localparam int IDX_L2 = 3;
    localparam int IDX_R2 = 4;
    localparam int IDX_F2 = 5;

    localparam int DEF_DB_CYCLES   = 4;
    localparam int DEF_FIRE_PERIOD = 8;

    typedef logic [NUM_BTN-1:0] btn_vec_t;

endpackage

// File: rtl/galaga_input_conditioner_debounce.sv
// One push-button channel: two-flop synchroniser, consecutive-sample debounce and
// a rising-edge strobe that is true during the cycle before the stable level goes high.
module button_debounce
    import galaga_input_pkg::*;
#(
    parameter int DB_CYCLES = DEF_DB_CYCLES
) (
    input  logic clk,
    input  logic rst_n,
    input  logic btn_raw,
    output logic level,
    output logic rise
);

    logic       meta_q, meta_d;
    logic       sync_q, sync_d;
    logic [7:0] cnt_q, cnt_d;
    logic       st_q, st_d;

    always_comb begin
        meta_d = btn_raw;
        sync_d = meta_q;
        st_d   = st_q;
        cnt_d  = 8'd0;
        // Any sample equal to the stable level leaves cnt_d at zero, restarting the run.
        if (sync_q != st_q) begin
            if (cnt_q == 8'(DB_CYCLES - 1)) begin
                st_d = sync_q;
            end else begin
                cnt_d = cnt_q + 8'd1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            meta_q <= 1'b0;
            sync_q <= 1'b0;
            cnt_q  <= 8'd0;
            st_q   <= 1'b0;
        end else begin
            meta_q <= meta_d;
            sync_q <= sync_d;
            cnt_q  <= cnt_d;
            st_q   <= st_d;
        end
    end

    assign level = st_q;
    assign rise  = st_d & ~st_q;

endmodule

// File: rtl/galaga_input_conditioner.sv
// Conditions six raw buttons into registered single-cycle command pulses for the GALAGA core.
// Optional autofire on the fire buttons is enabled with the GALAGA_AUTOFIRE_EN macro.
module galaga_input_conditioner
    import galaga_input_pkg::*;
#(
    parameter int DB_CYCLES = DEF_DB_CYCLES
`ifdef GALAGA_AUTOFIRE_EN
    ,
    parameter int FIRE_PERIOD = DEF_FIRE_PERIOD
`endif
) (
    input  logic       CLK,
    input  logic       RST,
    input  logic       BTN_L1,
    input  logic       BTN_R1,
    input  logic       BTN_F1,
    input  logic       BTN_L2,
    input  logic       BTN_R2,
    input  logic       BTN_F2,
    input  logic       DONE,
    output logic       LEFT,
    output logic       RIGHT,
    output logic       DP1,
    output logic       LEFT2,
    output logic       RIGHT2,
    output logic       DP2,
    output logic [5:0] HELD
);

    btn_vec_t   btn_raw;
    btn_vec_t   level;
    btn_vec_t   rise;
    btn_vec_t   pulse_d, pulse_q;
    logic [1:0] fire_rep;

    assign btn_raw[IDX_L1] = BTN_L1;
    assign btn_raw[IDX_R1] = BTN_R1;
    assign btn_raw[IDX_F1] = BTN_F1;
    assign btn_raw[IDX_L2] = BTN_L2;
    assign btn_raw[IDX_R2] = BTN_R2;
    assign btn_raw[IDX_F2] = BTN_F2;

    for (genvar i = 0; i < NUM_BTN; i++) begin : g_btn
        button_debounce #(
            .DB_CYCLES(DB_CYCLES)
        ) u_db (
            .clk    (CLK),
            .rst_n  (RST),
            .btn_raw(btn_raw[i]),
            .level  (level[i]),
            .rise   (rise[i])
        );
    end

`ifdef GALAGA_AUTOFIRE_EN
    logic [1:0] fire_rise;
    logic [1:0] fire_lvl;
    logic [7:0] rep_cnt_q [2];
    logic [7:0] rep_cnt_d [2];

    assign fire_rise = {rise[IDX_F2], rise[IDX_F1]};
    assign fire_lvl  = {level[IDX_F2], level[IDX_F1]};

    // Counter restarts on the initial press and idles at zero while the button is up.
    always_comb begin
        for (int p = 0; p < 2; p++) begin
            rep_cnt_d[p] = 8'd0;
            fire_rep[p]  = 1'b0;
            if (!fire_rise[p] && fire_lvl[p]) begin
                if (rep_cnt_q[p] == 8'(FIRE_PERIOD - 1)) begin
                    fire_rep[p] = 1'b1;
                end else begin
                    rep_cnt_d[p] = rep_cnt_q[p] + 8'd1;
                end
            end
        end
    end

    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            for (int p = 0; p < 2; p++) begin
                rep_cnt_q[p] <= 8'd0;
            end
        end else begin
            for (int p = 0; p < 2; p++) begin
                rep_cnt_q[p] <= rep_cnt_d[p];
            end
        end
    end
`else
    assign fire_rep = 2'b00;
`endif

    // Simultaneous left+right from one player cancel; DONE discards everything that cycle.
    always_comb begin
        pulse_d         = '0;
        pulse_d[IDX_L1] = rise[IDX_L1] & ~rise[IDX_R1];
        pulse_d[IDX_R1] = rise[IDX_R1] & ~rise[IDX_L1];
        pulse_d[IDX_F1] = rise[IDX_F1] | fire_rep[0];
        pulse_d[IDX_L2] = rise[IDX_L2] & ~rise[IDX_R2];
        pulse_d[IDX_R2] = rise[IDX_R2] & ~rise[IDX_L2];
        pulse_d[IDX_F2] = rise[IDX_F2] | fire_rep[1];
        if (DONE) begin
            pulse_d = '0;
        end
    end

    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            pulse_q <= '0;
        end else begin
            pulse_q <= pulse_d;
        end
    end

    assign LEFT   = pulse_q[IDX_L1];
    assign RIGHT  = pulse_q[IDX_R1];
    assign DP1    = pulse_q[IDX_F1];
    assign LEFT2  = pulse_q[IDX_L2];
    assign RIGHT2 = pulse_q[IDX_R2];
    assign DP2    = pulse_q[IDX_F2];
    assign HELD   = level;

endmodule
